inst_fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the combinational instruction ROM.
- Owns the program counter and drives the ROM byte address.
- Captures the returned instruction word with its PC into a small prefetch FIFO.
- Presents {inst, pc} to decode with a valid/ready handshake; decode/execute can redirect the PC on branch/jump.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/inst_fetch_unit_if.sv | 29 ++
 rtl/fetch_fifo.sv | 54 +++++
 rtl/inst_fetch_unit.sv | 74 +++++++
 tb/tb_inst_fetch_unit.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Latency: n/a (types only).
// Backpressure: n/a.
package fetch_pkg;

    // One prefetched instruction together with the byte address it came from.
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_entry_t;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// ROM, redirect and decode-side signals of the fetch stage (FETCH_PERF_EN adds perf counters).
// Latency: n/a (wiring only).
// Backpressure: decode holds iInstReady low to stall the head entry.
interface inst_fetch_unit_if;
    logic [31:0] oRomAddr;
    logic [31:0] iRomData;
    logic        iRedirect;
    logic [31:0] iRedirectPc;
    logic        oInstValid;
    logic        iInstReady;
    logic [31:0] oInst;
    logic [31:0] oInstPc;
`ifdef FETCH_PERF_EN
    logic [31:0] oFetchCnt;
    logic [31:0] oStallCnt;

    modport master (output oRomAddr, input iRomData, input iRedirect, input iRedirectPc,
                    output oInstValid, input iInstReady, output oInst, output oInstPc,
                    output oFetchCnt, output oStallCnt);
    modport slave  (input oRomAddr, output iRomData, output iRedirect, output iRedirectPc,
                    input oInstValid, output iInstReady, input oInst, input oInstPc,
                    input oFetchCnt, input oStallCnt);
`else
    modport master (output oRomAddr, input iRomData, input iRedirect, input iRedirectPc,
                    output oInstValid, input iInstReady, output oInst, output oInstPc);
    modport slave  (input oRomAddr, output iRomData, output iRedirect, output iRedirectPc,
                    input oInstValid, output iInstReady, input oInst, input oInstPc);
`endif
endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous prefetch FIFO of fetch entries; flush beats push/pop.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: push is ignored when full unless a pop frees a slot in the same cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wr_data,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          do_pop;
    logic          do_push;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

    // Entry storage; contents are meaningless until counted, so no reset needed.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the PC, reads the combinational ROM and queues {inst, pc} for decode.
// Latency: first entry valid 1 cycle after reset release; redirect target valid 2 cycles later.
// Backpressure: full FIFO without a pop freezes the PC; FETCH_PERF_EN adds fetch/stall counters.
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          BUF_DEPTH = 2
) (
    input  logic               iClk,
    input  logic               iRst,
    inst_fetch_unit_if.master  bus
);
    logic [31:0]  rFetchPc;
    logic         pop;
    logic         push;
    logic         full;
    logic         empty;
    fetch_entry_t wr_entry;
    fetch_entry_t head;

    // Valid depends only on registered occupancy, never on iInstReady.
    assign bus.oInstValid = ~empty;
    assign pop            = bus.oInstValid & bus.iInstReady;
    // A pop frees a slot this cycle, so a full FIFO still accepts a fetch when decode drains it.
    assign push           = ~bus.iRedirect & (~full | pop);

    assign bus.oRomAddr   = rFetchPc;
    assign wr_entry.inst  = bus.iRomData;
    assign wr_entry.pc    = rFetchPc;
    assign bus.oInst      = head.inst;
    assign bus.oInstPc    = head.pc;

    fetch_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk     (iClk),
        .rst     (iRst),
        .push    (push),
        .pop     (pop),
        .flush   (bus.iRedirect),
        .wr_data (wr_entry),
        .full    (full),
        .empty   (empty),
        .head    (head)
    );

    // Fetch PC: reset, then redirect (word-aligned), then advance on each accepted fetch.
    always_ff @(posedge iClk) begin
        if (iRst)               rFetchPc <= RESET_PC;
        else if (bus.iRedirect) rFetchPc <= bus.iRedirectPc & ~32'h3;
        else if (push)          rFetchPc <= rFetchPc + PC_STEP;
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;

    assign bus.oFetchCnt = fetch_cnt;
    assign bus.oStallCnt = stall_cnt;

    // Perf counters survive redirects; only reset clears them.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (push)                                fetch_cnt <= fetch_cnt + 32'd1;
            if (bus.oInstValid && !bus.iInstReady)   stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: stimulus queues expected {inst, pc}, monitor pops on handshake.
// Latency: n/a.
// Backpressure: exercised by holding iInstReady low in several phases.
module tb_inst_fetch_unit;
    import fetch_pkg::*;

    logic clk = 1'b0;
    logic rst;
    integer n_tests = 0;
    integer n_fail  = 0;
    fetch_entry_t exp_q[$];

    inst_fetch_unit_if bus ();

    inst_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        return 32'h1000_0000 + (addr >> 2);
    endfunction

    // Combinational ROM: word i holds 0x1000_0000 + i.
    assign bus.iRomData = rom_word(bus.oRomAddr);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_run(input logic [31:0] pc0, input int n);
        logic [31:0] pc;
        for (int i = 0; i < n; i++) begin
            pc = pc0 + 32'(4 * i);
            exp_q.push_back('{inst: rom_word(pc), pc: pc});
        end
    endtask

    // Monitor: every real handshake must match the oldest expected entry.
    always @(negedge clk) begin
        fetch_entry_t e;
        if (rst === 1'b0 && bus.iRedirect === 1'b0 &&
            bus.oInstValid === 1'b1 && bus.iInstReady === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pop: got pc %h, expected no transfer", bus.oInstPc);
            end else begin
                e = exp_q.pop_front();
                check("pop", {bus.oInst, bus.oInstPc}, e);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        bus.iInstReady  = 1'b1;
        bus.iRedirect   = 1'b0;
        bus.iRedirectPc = 32'h0;
        step(2);
        check("reset_valid", 64'(bus.oInstValid), 64'd0);
        check("reset_addr", 64'(bus.oRomAddr), 64'h0);

        // Free-run: one instruction per cycle from RESET_PC, no gaps.
        rst = 1'b0;
        expect_run(32'h0, 8);
        step(9);
        bus.iInstReady = 1'b0;
        check("freerun_drain", 64'(exp_q.size()), 64'd0);

        // Backpressure after reset: FIFO fills to two, PC parks at 0x08.
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(5);
        check("bp_addr", 64'(bus.oRomAddr), 64'h8);
        check("bp_valid", 64'(bus.oInstValid), 64'd1);
        check("bp_head", {bus.oInst, bus.oInstPc}, {32'h1000_0000, 32'h0});
        expect_run(32'h0, 4);
        bus.iInstReady = 1'b1;
        step(4);
        bus.iInstReady = 1'b0;
        check("bp_drain", 64'(exp_q.size()), 64'd0);

        // Redirect while full: same-cycle pop is dropped, one bubble, then target.
        bus.iInstReady  = 1'b1;
        bus.iRedirect   = 1'b1;
        bus.iRedirectPc = 32'h0000_00A0;
        step(1);
        bus.iRedirect = 1'b0;
        check("redir_valid", 64'(bus.oInstValid), 64'd0);
        check("redir_addr", 64'(bus.oRomAddr), 64'hA0);
        expect_run(32'hA0, 2);
        step(3);
        bus.iInstReady = 1'b0;
        check("redir_drain", 64'(exp_q.size()), 64'd0);

        // Misaligned redirect target: low bits cleared.
        bus.iRedirect   = 1'b1;
        bus.iRedirectPc = 32'h0000_00A6;
        step(1);
        bus.iRedirect = 1'b0;
        check("misalign_valid", 64'(bus.oInstValid), 64'd0);
        check("misalign_addr", 64'(bus.oRomAddr), 64'hA4);
        expect_run(32'hA4, 2);
        bus.iInstReady = 1'b1;
        step(3);
        bus.iInstReady = 1'b0;
        check("misalign_drain", 64'(exp_q.size()), 64'd0);

        // PC wrap at the top of the address space.
        bus.iInstReady  = 1'b1;
        bus.iRedirect   = 1'b1;
        bus.iRedirectPc = 32'hFFFF_FFF8;
        step(1);
        bus.iRedirect = 1'b0;
        expect_run(32'hFFFF_FFF8, 4);
        step(5);
        bus.iInstReady = 1'b0;
        check("wrap_drain", 64'(exp_q.size()), 64'd0);

        // Reset mid-run with a full FIFO and PC at 0x30.
        bus.iRedirect   = 1'b1;
        bus.iRedirectPc = 32'h0000_0028;
        step(1);
        bus.iRedirect = 1'b0;
        step(2);
        check("pre_rst_addr", 64'(bus.oRomAddr), 64'h30);
        check("pre_rst_valid", 64'(bus.oInstValid), 64'd1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("midrst_valid", 64'(bus.oInstValid), 64'd0);
        check("midrst_addr", 64'(bus.oRomAddr), 64'h0);
        // Reset and redirect together: reset wins.
        rst             = 1'b1;
        bus.iRedirect   = 1'b1;
        bus.iRedirectPc = 32'h0000_0080;
        step(1);
        rst           = 1'b0;
        bus.iRedirect = 1'b0;
        check("rst_vs_redir_addr", 64'(bus.oRomAddr), 64'h0);
        check("rst_vs_redir_valid", 64'(bus.oInstValid), 64'd0);
        expect_run(32'h0, 2);
        bus.iInstReady = 1'b1;
        step(3);
        bus.iInstReady = 1'b0;
        check("rst_drain", 64'(exp_q.size()), 64'd0);

        // Ten transfers, then three stalled cycles with a valid head.
        rst = 1'b1;
        step(2);
        rst            = 1'b0;
        bus.iInstReady = 1'b1;
        expect_run(32'h0, 10);
        step(11);
        bus.iInstReady = 1'b0;
        step(3);
        check("stall_head", {bus.oInstValid, bus.oInstPc}, {31'd0, 1'b1, 32'h28});
`ifdef FETCH_PERF_EN
        check("perf_fetch", 64'(bus.oFetchCnt), 64'd12);
        check("perf_stall", 64'(bus.oStallCnt), 64'd3);
`endif
        bus.iInstReady  = 1'b1;
        bus.iRedirect   = 1'b1;
        bus.iRedirectPc = 32'h0000_0040;
        step(1);
        bus.iRedirect  = 1'b0;
        bus.iInstReady = 1'b0;
`ifdef FETCH_PERF_EN
        check("perf_fetch_redir", 64'(bus.oFetchCnt), 64'd12);
        check("perf_stall_redir", 64'(bus.oStallCnt), 64'd3);
`endif
        check("perf_drain", 64'(exp_q.size()), 64'd0);

        step(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
